// File: rtl/shift_register_universal.sv
`default_nettype none
// ============================================================================
// Module   : shift_register_universal
// Purpose  : Parametrised universal shift register. Supports hold, logical
//            shift right/left with serial inputs, rotate right/left,
//            arithmetic shift right, parallel load and synchronous clear,
//            gated by a clock enable. A shift-count tracker raises busy
//            after a parallel load and emits a one-cycle done pulse once
//            the loaded word has been shifted N times.
//
// Ports    : clk      - rising-edge clock
//            reset_n  - asynchronous active-low reset
//            en       - clock enable (0 = hold everything, done forced 0)
//            mode     - operation select
//                         000 hold        001 shift right   010 shift left
//                         011 rotate right 100 rotate left  101 arith right
//                         110 load        111 clear
//            SI_R     - serial input entering at bit N-1 on shift right
//            SI_L     - serial input entering at bit 0 on shift left
//            I        - parallel load data
//            Q        - register contents
//            SO_R     - right-shift serial out (Q[0])
//            SO_L     - left-shift serial out (Q[N-1])
//            busy     - loaded word not yet fully shifted out
//            done     - one-cycle pulse after the N-th shift following a load
//
// Revision : 1.0 - initial release
// ============================================================================
module shift_register_universal #(
  parameter int N = 8
) (
  input  logic         clk,
  input  logic         reset_n,
  input  logic         en,
  input  logic [2:0]   mode,
  input  logic         SI_R,
  input  logic         SI_L,
  input  logic [N-1:0] I,
  output logic [N-1:0] Q,
  output logic         SO_R,
  output logic         SO_L,
  output logic         busy,
  output logic         done
);

  // Counter must be able to represent 0..N.
  localparam int CW = $clog2(N + 1);

  // Counter value seen just before the completing (N-th) shift.
  localparam logic [CW-1:0] LAST_COUNT = CW'(N - 1);

  localparam logic [2:0] MODE_HOLD  = 3'b000;
  localparam logic [2:0] MODE_SHR   = 3'b001;
  localparam logic [2:0] MODE_SHL   = 3'b010;
  localparam logic [2:0] MODE_ROR   = 3'b011;
  localparam logic [2:0] MODE_ROL   = 3'b100;
  localparam logic [2:0] MODE_ASR   = 3'b101;
  localparam logic [2:0] MODE_LOAD  = 3'b110;
  localparam logic [2:0] MODE_CLEAR = 3'b111;

  logic [N-1:0]  q_next;
  logic          is_shift;
  logic [CW-1:0] count;
  logic [CW-1:0] count_next;
  logic          busy_next;
  logic          done_next;

  // --------------------------------------------------------------------------
  // Data path: next register value for the selected operation.
  // --------------------------------------------------------------------------
  always_comb begin
    q_next   = Q;
    is_shift = 1'b0;
    case (mode)
      MODE_HOLD: begin
        q_next = Q;
      end
      MODE_SHR: begin
        q_next   = {SI_R, Q[N-1:1]};
        is_shift = 1'b1;
      end
      MODE_SHL: begin
        q_next   = {Q[N-2:0], SI_L};
        is_shift = 1'b1;
      end
      MODE_ROR: begin
        q_next   = {Q[0], Q[N-1:1]};
        is_shift = 1'b1;
      end
      MODE_ROL: begin
        q_next   = {Q[N-2:0], Q[N-1]};
        is_shift = 1'b1;
      end
      MODE_ASR: begin
        // Sign bit is replicated into the vacated MSB.
        q_next   = {Q[N-1], Q[N-1:1]};
        is_shift = 1'b1;
      end
      MODE_LOAD: begin
        q_next = I;
      end
      MODE_CLEAR: begin
        q_next = '0;
      end
      default: begin
        q_next = Q;
      end
    endcase
  end

  // --------------------------------------------------------------------------
  // Shift-count tracker. Only shifts of a loaded word count; shifts while
  // idle move data but leave the tracker alone. A reload while busy simply
  // restarts the count, so the abandoned word never reports done.
  // --------------------------------------------------------------------------
  always_comb begin
    count_next = count;
    busy_next  = busy;
    done_next  = 1'b0;
    if (en) begin
      if (mode == MODE_LOAD) begin
        count_next = '0;
        busy_next  = 1'b1;
      end else if (mode == MODE_CLEAR) begin
        count_next = '0;
        busy_next  = 1'b0;
      end else if (is_shift && busy) begin
        if (count == LAST_COUNT) begin
          count_next = '0;
          busy_next  = 1'b0;
          done_next  = 1'b1;
        end else begin
          count_next = count + CW'(1);
        end
      end
    end
  end

  // --------------------------------------------------------------------------
  // State registers.
  // --------------------------------------------------------------------------
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      Q     <= '0;
      count <= '0;
      busy  <= 1'b0;
      done  <= 1'b0;
    end else begin
      if (en) begin
        Q <= q_next;
      end
      count <= count_next;
      busy  <= busy_next;
      // done_next is 0 whenever en is low, so done is a pure one-cycle pulse.
      done  <= done_next;
    end
  end

  // Serial outputs are taps of the register, no extra delay.
  assign SO_R = Q[0];
  assign SO_L = Q[N-1];

endmodule
`default_nettype wire

// File: tb/tb_shift_register_universal.sv
`default_nettype none
// ============================================================================
// Module   : tb_shift_register_universal
// Purpose  : Self-checking bench for shift_register_universal. Drives an
//            N=8 and an N=4 instance with identical stimulus, tracks both
//            with a behavioural model and adds literal expectations from
//            hand-worked sequences.
// Revision : 1.0 - initial release
// ============================================================================
module tb_shift_register_universal;

  logic       clk = 1'b0;
  logic       reset_n;
  logic       en;
  logic [2:0] mode;
  logic       si_r;
  logic       si_l;
  logic [7:0] din;

  logic [7:0] q8;
  logic       sor8, sol8, busy8, done8;
  logic [3:0] q4;
  logic       sor4, sol4, busy4, done4;

  int passed = 0;
  int total  = 0;

  always #5 clk = ~clk;

  shift_register_universal #(.N(8)) dut8 (
    .clk(clk), .reset_n(reset_n), .en(en), .mode(mode),
    .SI_R(si_r), .SI_L(si_l), .I(din),
    .Q(q8), .SO_R(sor8), .SO_L(sol8), .busy(busy8), .done(done8)
  );

  shift_register_universal #(.N(4)) dut4 (
    .clk(clk), .reset_n(reset_n), .en(en), .mode(mode),
    .SI_R(si_r), .SI_L(si_l), .I(din[3:0]),
    .Q(q4), .SO_R(sor4), .SO_L(sol4), .busy(busy4), .done(done4)
  );

  // --------------------------------------------------------------------------
  // Behavioural model: index 0 is the 8-bit instance, index 1 the 4-bit one.
  // A word is tracked as "shifts remaining", counting down from the width.
  // --------------------------------------------------------------------------
  int unsigned mq   [2];
  int          mrem [2];
  bit          mdone[2];
  int          wid  [2] = '{8, 4};
  bit          model_valid = 1'b0;

  function automatic void model_reset();
    for (int k = 0; k < 2; k++) begin
      mq[k]    = 0;
      mrem[k]  = 0;
      mdone[k] = 1'b0;
    end
  endfunction

  function automatic void model_step();
    for (int k = 0; k < 2; k++) begin
      int unsigned w    = wid[k];
      int unsigned mask = (1 << w) - 1;
      int unsigned q    = mq[k];
      int unsigned msb  = (q >> (w - 1)) & 1;
      int unsigned lsb  = q & 1;
      bit          shift_op = (mode >= 3'd1) && (mode <= 3'd5);
      mdone[k] = 1'b0;
      if (en) begin
        case (mode)
          3'd1: q = (q >> 1) | (int'(si_r) << (w - 1));
          3'd2: q = ((q << 1) | int'(si_l)) & mask;
          3'd3: q = (q >> 1) | (lsb << (w - 1));
          3'd4: q = ((q << 1) | msb) & mask;
          3'd5: q = (q >> 1) | (msb << (w - 1));
          3'd6: begin q = int'(din) & mask; mrem[k] = w; end
          3'd7: begin q = 0; mrem[k] = 0; end
          default: ;
        endcase
        if (shift_op && mrem[k] > 0) begin
          mrem[k] = mrem[k] - 1;
          if (mrem[k] == 0) mdone[k] = 1'b1;
        end
        mq[k] = q;
      end
    end
  endfunction

  task automatic chk(input string name, input longint got, input longint exp);
    total++;
    if (got == exp) passed++;
    else $display("FAIL %s: got %0h expected %0h at %0t", name, got, exp, $time);
  endtask

  // Single compare process: every falling edge, DUT against model.
  always @(negedge clk) begin
    if (model_valid) begin
      chk("q8",    q8,    mq[0]);
      chk("sor8",  sor8,  mq[0] & 1);
      chk("sol8",  sol8,  (mq[0] >> 7) & 1);
      chk("busy8", busy8, mrem[0] > 0);
      chk("done8", done8, mdone[0]);
      chk("q4",    q4,    mq[1]);
      chk("sor4",  sor4,  mq[1] & 1);
      chk("sol4",  sol4,  (mq[1] >> 3) & 1);
      chk("busy4", busy4, mrem[1] > 0);
      chk("done4", done4, mdone[1]);
    end
  end

  // Apply inputs (called at a falling edge), cross one rising edge, advance
  // the model, return at the next falling edge.
  task automatic step(input logic e, input logic [2:0] m, input logic sr,
                      input logic sl, input logic [7:0] d);
    en   = e;
    mode = m;
    si_r = sr;
    si_l = sl;
    din  = d;
    @(posedge clk);
    model_step();
    @(negedge clk);
  endtask

  initial begin
    logic [7:0] pat;
    logic [3:0] pat4;
    int         dcount;

    reset_n = 1'b0;
    en = 1'b0; mode = 3'd0; si_r = 1'b0; si_l = 1'b0; din = 8'h00;
    repeat (2) @(negedge clk);
    chk("rst_q8",    q8,    0);
    chk("rst_busy8", busy8, 0);
    chk("rst_done8", done8, 0);
    chk("rst_so8",   {sor8, sol8}, 0);
    chk("rst_q4",    q4,    0);
    reset_n = 1'b1;
    model_reset();
    model_valid = 1'b1;

    // Load A5 and shift right eight times, watching SO_R before each edge.
    step(1, 3'd6, 0, 0, 8'hA5);
    pat = 8'hA5;
    for (int i = 0; i < 8; i++) begin
      chk("t1_sor", sor8, pat[i]);
      chk("t1_busy_pre", busy8, 1);
      step(1, 3'd1, 0, 0, 8'h00);
    end
    chk("t1_q", q8, 8'h00);
    chk("t1_busy", busy8, 0);
    chk("t1_done", done8, 1);
    step(1, 3'd0, 0, 0, 8'h00);
    chk("t1_done_off", done8, 0);

    // Rotate right eight times returns the word, one done.
    step(1, 3'd6, 0, 0, 8'h81);
    dcount = 0;
    for (int i = 0; i < 8; i++) begin
      step(1, 3'd3, 0, 0, 8'h00);
      if (done8) dcount++;
    end
    step(1, 3'd0, 0, 0, 8'h00);
    if (done8) dcount++;
    chk("t2_q", q8, 8'h81);
    chk("t2_dones", dcount, 1);

    // Arithmetic shift right of a negative word.
    step(1, 3'd6, 0, 0, 8'h80);
    repeat (3) step(1, 3'd5, 0, 0, 8'h00);
    chk("t2_asr_q", q8, 8'hF0);
    chk("t2_asr_busy", busy8, 1);
    chk("t2_asr_done", done8, 0);

    // Reload while busy abandons the first word.
    step(1, 3'd6, 0, 1, 8'h0F);
    dcount = 0;
    for (int i = 0; i < 4; i++) begin
      step(1, 3'd2, 0, 1, 8'h00);
      if (done8) dcount++;
    end
    chk("t3_q_mid", q8, 8'hFF);
    step(1, 3'd6, 0, 1, 8'h33);
    if (done8) dcount++;
    chk("t3_no_done", dcount, 0);
    for (int i = 0; i < 8; i++) begin
      step(1, 3'd2, 0, 1, 8'h00);
      if (done8) dcount++;
    end
    step(1, 3'd0, 0, 1, 8'h00);
    if (done8) dcount++;
    chk("t3_dones", dcount, 1);
    chk("t3_q", q8, 8'hFF);

    // Clock enable freezes data and tracker.
    step(1, 3'd6, 0, 0, 8'h3C);
    repeat (2) step(1, 3'd1, 0, 0, 8'h00);
    for (int i = 0; i < 5; i++) begin
      step(0, 3'd1, 0, 0, 8'h00);
      chk("t4_q_frozen", q8, 8'h0F);
      chk("t4_busy_frozen", busy8, 1);
      chk("t4_done_frozen", done8, 0);
    end
    for (int i = 0; i < 6; i++) begin
      step(1, 3'd1, 0, 0, 8'h00);
      chk("t4_done", done8, (i == 5));
    end

    // Synchronous clear aborts without done.
    step(1, 3'd6, 0, 0, 8'hFF);
    repeat (3) step(1, 3'd1, 0, 0, 8'h00);
    chk("t5_q_pre", q8, 8'h1F);
    step(1, 3'd7, 0, 0, 8'h00);
    chk("t5_clr_q", q8, 0);
    chk("t5_clr_busy", busy8, 0);
    chk("t5_clr_done", done8, 0);
    step(1, 3'd1, 0, 0, 8'h00);
    chk("t5_clr_done2", done8, 0);

    // Asynchronous reset in the middle of a busy word.
    step(1, 3'd6, 0, 0, 8'hC3);
    step(1, 3'd1, 0, 0, 8'h00);
    en = 1'b1; mode = 3'd1;
    @(posedge clk);
    model_step();
    #2 reset_n = 1'b0;
    model_reset();
    #1;
    chk("t5_arst_q8", q8, 0);
    chk("t5_arst_busy8", busy8, 0);
    chk("t5_arst_done8", done8, 0);
    chk("t5_arst_q4", q4, 0);
    @(negedge clk);
    reset_n = 1'b1;

    // Four-bit instance: load 9, shift left with SI_L=0.
    step(1, 3'd6, 0, 0, 8'h09);
    pat4 = 4'h9;
    for (int i = 0; i < 4; i++) begin
      chk("t6_sol4", sol4, pat4[3 - i]);
      step(1, 3'd2, 0, 0, 8'h00);
    end
    chk("t6_q4", q4, 4'h0);
    chk("t6_done4", done4, 1);
    step(1, 3'd0, 0, 0, 8'h00);
    chk("t6_done4_off", done4, 0);

    // Randomised traffic, weighted towards shift operations.
    for (int i = 0; i < 3000; i++) begin
      int r;
      logic [2:0] m;
      r = $urandom_range(0, 15);
      if (r < 10)      m = 3'(1 + (r % 5));
      else if (r < 12) m = 3'd6;
      else if (r < 13) m = 3'd7;
      else             m = 3'd0;
      step(($urandom_range(0, 7) != 0), m, 1'($urandom), 1'($urandom),
           8'($urandom));
    end

    $display("%0d/%0d checks passed", passed, total);
    $finish;
  end

endmodule
`default_nettype wire

// File: doc/shift_register_universal.md
Name: shift_register_universal

Overview:
- Parametrised universal shift register; next generation of the team's serial-in/parallel-load shifter.
- Adds the following over that shifter:
  - bidirectional shift
  - rotate
  - arithmetic shift
  - synchronous clear
  - clock enable
  - a shift-count tracker that flags when a loaded word has been fully shifted out
- Used as the serialiser/deserialiser core behind the team's serial links and as a generic data-path shifter.

Parameters:
- N, 8, register width in bits; legal range N >= 2.

Ports:
- clk  input  1  clock; all state updates on the rising edge.
- reset_n  input  1  asynchronous, active-low reset.
- en  input  1  clock enable; when 0 the register holds regardless of mode.
- mode  input  3  operation select (encoding below).
- SI_R  input  1  serial input entering at bit N-1 on right shift.
- SI_L  input  1  serial input entering at bit 0 on left shift.
- I  input  N  parallel load data.
- Q  output  N  register contents.
- SO_R  output  1  right-shift serial out = Q[0].
- SO_L  output  1  left-shift serial out = Q[N-1].
- busy  output  1  loaded word not yet fully shifted.
- done  output  1  one-cycle pulse marking completion of the N-th shift after a load.

Behaviour:
- Reset (reset_n low, asynchronous): Q=0, internal count=0, busy=0, done=0. SO_R and SO_L follow Q, so both are 0.
- Reset deassertion is synchronised externally; the first active edge after release applies normal operation.
- Mode encoding, applied at the rising edge when en=1:
  - 000 hold.
  - 001 shift right: Q <= {SI_R, Q[N-1:1]}.
  - 010 shift left: Q <= {Q[N-2:0], SI_L}.
  - 011 rotate right: Q <= {Q[0], Q[N-1:1]}.
  - 100 rotate left: Q <= {Q[N-2:0], Q[N-1]}.
  - 101 arithmetic shift right: Q <= {Q[N-1], Q[N-1:1]}.
  - 110 parallel load: Q <= I.
  - 111 synchronous clear: Q <= 0.
- en=0: Q, count and busy hold; done is driven 0.
- Shift class: modes 001-101 are "shift operations".
- Count width: ceil(log2(N+1)) bits.
- Load (110, en=1): count <= 0, busy <= 1, done <= 0. This also applies when already busy; the count restarts and no done is produced for the abandoned word.
- Shift operation with busy=1:
  - count increments.
  - If count == N-1 before the edge (this is the N-th shift): busy <= 0, count <= 0, done <= 1 for exactly the following cycle.
- Shift operation with busy=0: Q shifts normally; count, busy and done are unaffected (done = 0).
- Hold (000) while busy: busy and count hold; done = 0.
- Clear (111): Q=0, count=0, busy=0, done=0. This aborts any word in progress without a done pulse.
- done is registered; it is high only in the cycle after the completing edge and is otherwise 0.
- No back-to-back done is possible without an intervening load.
- Latency:
  - Q reflects an operation one cycle after the edge that samples it.
  - SO_R and SO_L are combinational from Q, with no additional delay.
- Mixing directions while busy, e.g. left then right: each shift operation counts regardless of direction.
- Reset mid-operation: immediate return to reset values; any in-progress word is lost and no done is produced.

Test Plan:
- Reset then load I=8'hA5, eight mode=001 shifts with SI_R=0, sampling SO_R before each edge:
  - SO_R sequence is 1,0,1,0,0,1,0,1.
  - Q=8'h00 at end.
  - busy drops at the 8th edge.
  - done=1 for exactly one cycle after it.
- Load 8'h81, eight mode=011 rotates -> Q=8'h81 again, done pulses once. Load 8'h80, three mode=101 shifts -> Q=8'hF0, busy=1, done=0.
- Load 8'h0F, four mode=010 shifts with SI_L=1, then load 8'h33, then eight shifts:
  - no done after the first four shifts.
  - exactly one done after the eighth shift following the second load.
  - Q=8'hFF with SI_L=1.
- Load 8'h3C, two shifts, en=0 for 5 cycles with mode=001, then resume:
  - Q and busy frozen during the en=0 cycles.
  - done arrives only after 6 further shifts.
- Load 8'hFF, three shifts, mode=111 -> Q=0, busy=0, no done. Then assert reset_n=0 asynchronously mid-shift during a busy word -> Q=0, busy=0, done=0 immediately, without waiting for clk.
- N=4 instance: load 4'h9, mode=010 four times with SI_L=0 -> SO_L sequence 1,0,0,1, Q=4'h0, done one-cycle pulse.
